// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: GRS width, level-count helpers and the aligned-mantissa
// result struct consumed by the rounding stage.
package fp_pkg;

    localparam int unsigned GRS_W    = 3;
    localparam int unsigned FP_MAN_W = 24;

    // Aligned significand with guard, round and sticky bits appended.
    typedef struct packed {
        logic [FP_MAN_W-1:0] man;
        logic                g;
        logic                r;
        logic                s;
    } man_grs_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Number of barrel levels owned by pipeline stage k; earlier stages take the remainder.
    function automatic int unsigned stage_num_lvls(input int unsigned k,
                                                   input int unsigned lvls,
                                                   input int unsigned stages);
        return (lvls / stages) + ((k < (lvls % stages)) ? 1 : 0);
    endfunction

    // Index of the first barrel level owned by pipeline stage k.
    function automatic int unsigned stage_first_lvl(input int unsigned k,
                                                    input int unsigned lvls,
                                                    input int unsigned stages);
        return k * (lvls / stages) + ((k < (lvls % stages)) ? k : (lvls % stages));
    endfunction

endpackage

// File: rtl/man_shift_level.sv
// One barrel-shifter level: conditional logical right shift by a fixed distance D, also
// reporting the OR of the bits pushed out so the caller can fold them into sticky.
module man_shift_level
    import fp_pkg::*;
#(
    parameter int unsigned W = 26,
    parameter int unsigned D = 1
) (
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         drop_o
);

    logic [W-1:0] shifted;
    logic         dropped;

    if (D >= W) begin : g_all
        assign shifted = '0;
        assign dropped = |data_i;
    end else begin : g_part
        assign shifted = data_i >> D;
        assign dropped = |data_i[D-1:0];
    end

    // Pass data through untouched when this level's shift bit is clear.
    always_comb begin
        data_o = en_i ? shifted : data_i;
        drop_o = en_i & dropped;
    end

endmodule

// File: rtl/man_shiftr_pipe.sv
// Pipelined mantissa right-shifter for FP add alignment. Produces {shifted man, G, R, S}
// with per-level sticky accumulation, valid/ready flow control and a sideband tag.
// Optional build macro MAN_SHIFTR_SAT_EN adds the pipelined out_sat flag.
module man_shiftr_pipe
    import fp_pkg::*;
#(
    parameter int unsigned MAN_W   = 24,
    parameter int unsigned SHAMT_W = 8,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN_W-1:0]   in_man,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W+2:0]   out_res,
`ifdef MAN_SHIFTR_SAT_EN
    output logic               out_sat,
`endif
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned EXT_W = MAN_W + 2;
    localparam int unsigned LVLS  = clog2(EXT_W);

    logic             sat;
    logic [EXT_W-1:0] front_data;
    logic             front_sticky;
    logic [LVLS-1:0]  front_amt;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] rdy;
    logic [EXT_W-1:0]  src_data   [STAGES];
    logic [EXT_W-1:0]  data_d     [STAGES];
    logic [EXT_W-1:0]  data_q     [STAGES];
    logic              src_sticky [STAGES];
    logic              sticky_d   [STAGES];
    logic              sticky_q   [STAGES];
    logic [LVLS-1:0]   src_amt    [STAGES];
    logic [LVLS-1:0]   amt_q      [STAGES];
    logic [TAG_W-1:0]  src_tag    [STAGES];
    logic [TAG_W-1:0]  tag_q      [STAGES];
`ifdef MAN_SHIFTR_SAT_EN
    logic              src_sat    [STAGES];
    logic              sat_q      [STAGES];
`endif

    // Oversized shifts bypass the barrel: nothing survives, every mantissa bit goes to sticky.
    always_comb begin
        sat          = 32'(in_shamt) >= EXT_W;
        front_data   = sat ? '0 : {in_man, 2'b00};
        front_sticky = sat & (|in_man);
        front_amt    = in_shamt[LVLS-1:0];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned FIRST = stage_first_lvl(k, LVLS, STAGES);
        localparam int unsigned NUM   = stage_num_lvls(k, LVLS, STAGES);

        // Stage k may load if any stage from k to the output is empty or the output drains.
        assign rdy[k] = out_ready | ~(&valid_q[STAGES-1:k]);

        if (k == 0) begin : g_src_in
            assign src_valid[k]  = in_valid;
            assign src_data[k]   = front_data;
            assign src_sticky[k] = front_sticky;
            assign src_amt[k]    = front_amt;
            assign src_tag[k]    = in_tag;
`ifdef MAN_SHIFTR_SAT_EN
            assign src_sat[k]    = sat;
`endif
        end else begin : g_src_stage
            assign src_valid[k]  = valid_q[k-1];
            assign src_data[k]   = data_q[k-1];
            assign src_sticky[k] = sticky_q[k-1];
            assign src_amt[k]    = amt_q[k-1];
            assign src_tag[k]    = tag_q[k-1];
`ifdef MAN_SHIFTR_SAT_EN
            assign src_sat[k]    = sat_q[k-1];
`endif
        end

        for (genvar i = 0; i < NUM; i++) begin : g_lvl
            logic [EXT_W-1:0] d_in;
            logic [EXT_W-1:0] d_out;
            logic             s_in;
            logic             s_out;
            logic             drop;

            if (i == 0) begin : g_head
                assign d_in = src_data[k];
                assign s_in = src_sticky[k];
            end else begin : g_tail
                assign d_in = g_lvl[i-1].d_out;
                assign s_in = g_lvl[i-1].s_out;
            end

            man_shift_level #(
                .W (EXT_W),
                .D (32'd1 << (FIRST + i))
            ) u_level (
                .en_i   (src_amt[k][FIRST+i]),
                .data_i (d_in),
                .data_o (d_out),
                .drop_o (drop)
            );

            assign s_out = s_in | drop;
        end

        if (NUM == 0) begin : g_pass
            assign data_d[k]   = src_data[k];
            assign sticky_d[k] = src_sticky[k];
        end else begin : g_out
            assign data_d[k]   = g_lvl[NUM-1].d_out;
            assign sticky_d[k] = g_lvl[NUM-1].s_out;
        end
    end

    // Stage registers: a stage loads when it has room; payload is captured only for real beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i]   <= '0;
                sticky_q[i] <= 1'b0;
                amt_q[i]    <= '0;
                tag_q[i]    <= '0;
`ifdef MAN_SHIFTR_SAT_EN
                sat_q[i]    <= 1'b0;
`endif
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    valid_q[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        data_q[i]   <= data_d[i];
                        sticky_q[i] <= sticky_d[i];
                        amt_q[i]    <= src_amt[i];
                        tag_q[i]    <= src_tag[i];
`ifdef MAN_SHIFTR_SAT_EN
                        sat_q[i]    <= src_sat[i];
`endif
                    end
                end
            end
        end
    end

    // Outputs come straight from the last stage; in_ready ripples back from out_ready.
    always_comb begin
        in_ready  = rdy[0];
        out_valid = valid_q[STAGES-1];
        out_res   = {data_q[STAGES-1], sticky_q[STAGES-1]};
        out_tag   = tag_q[STAGES-1];
`ifdef MAN_SHIFTR_SAT_EN
        out_sat   = sat_q[STAGES-1];
`endif
    end

endmodule

// File: tb/tb_man_shiftr_pipe.sv
// Self-checking bench for man_shiftr_pipe (STAGES=2 main, plus STAGES=1 and 4 for the sweep).
`timescale 1ns/1ps
module tb_man_shiftr_pipe;

    localparam int unsigned MAN_W   = 24;
    localparam int unsigned SHAMT_W = 8;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned EXT_W   = MAN_W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid;
    logic [MAN_W-1:0]   in_man;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_ready;

    logic               in_ready,  in_ready1,  in_ready4;
    logic               out_valid, out_valid1, out_valid4;
    logic [MAN_W+2:0]   out_res,   out_res1,   out_res4;
    logic [TAG_W-1:0]   out_tag,   out_tag1,   out_tag4;
`ifdef MAN_SHIFTR_SAT_EN
    logic               out_sat,   out_sat1,   out_sat4;
`endif

    int checks   = 0;
    int failures = 0;

    man_shiftr_pipe #(.MAN_W(MAN_W), .SHAMT_W(SHAMT_W), .STAGES(2), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_man    (in_man),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
`ifdef MAN_SHIFTR_SAT_EN
        .out_sat   (out_sat),
`endif
        .out_tag   (out_tag)
    );

    man_shiftr_pipe #(.MAN_W(MAN_W), .SHAMT_W(SHAMT_W), .STAGES(1), .TAG_W(TAG_W)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_man    (in_man),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_res   (out_res1),
`ifdef MAN_SHIFTR_SAT_EN
        .out_sat   (out_sat1),
`endif
        .out_tag   (out_tag1)
    );

    man_shiftr_pipe #(.MAN_W(MAN_W), .SHAMT_W(SHAMT_W), .STAGES(4), .TAG_W(TAG_W)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_man    (in_man),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_res   (out_res4),
`ifdef MAN_SHIFTR_SAT_EN
        .out_sat   (out_sat4),
`endif
        .out_tag   (out_tag4)
    );

    // Reference: shift {man,00} right by s, sticky = OR of everything shifted out.
    function automatic logic [MAN_W+2:0] ref_res(input logic [MAN_W-1:0] man, input int unsigned s);
        logic [63:0] ext;
        logic [63:0] mask;
        ext = 64'(man) << 2;
        if (s >= EXT_W) return {{(MAN_W+2){1'b0}}, |man};
        mask = (64'd1 << s) - 64'd1;
        return {EXT_W'(ext >> s), ((ext & mask) != 64'd0)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [MAN_W-1:0] m, input logic [SHAMT_W-1:0] s,
                         input logic [TAG_W-1:0] t);
        in_valid = v;
        in_man   = m;
        in_shamt = s;
        in_tag   = t;
    endtask

    // Send one beat on the main DUT with out_ready high and collect its result.
    task automatic run_one(input logic [MAN_W-1:0] m, input logic [SHAMT_W-1:0] s,
                           input logic [TAG_W-1:0] t, output logic [MAN_W+2:0] res,
                           output logic [TAG_W-1:0] tag, output logic sat, output int lat);
        int w;
        out_ready = 1'b1;
        drive(1'b1, m, s, t);
        #1;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        res = out_res;
        tag = out_tag;
`ifdef MAN_SHIFTR_SAT_EN
        sat = out_sat;
`else
        sat = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_res !== '0) begin
            failures++; $display("FAIL reset_out_res: got %h want 0", out_res);
        end
        checks++;
        if (out_tag !== '0) begin
            failures++; $display("FAIL reset_out_tag: got %h want 0", out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef MAN_SHIFTR_SAT_EN
        checks++;
        if (out_sat !== 1'b0) begin
            failures++; $display("FAIL reset_out_sat: got %b want 0", out_sat);
        end
`endif
        step();
    endtask

    task automatic test_directed();
        logic [MAN_W-1:0]   d_man [6];
        logic [SHAMT_W-1:0] d_sh  [6];
        logic [MAN_W+2:0]   d_exp [6];
        logic [MAN_W+2:0]   res;
        logic [TAG_W-1:0]   tag;
        logic               sat;
        int                 lat;
        d_man = '{24'h800001, 24'h800001, 24'h800001, 24'h800001, 24'h800001, 24'h000000};
        d_sh  = '{8'd0, 8'd3, 8'd1, 8'd26, 8'd255, 8'd40};
        d_exp = '{27'h4000008, 27'h0800001, 27'h2000004, 27'h0000001, 27'h0000001, 27'h0000000};
        for (int i = 0; i < 6; i++) begin
            run_one(d_man[i], d_sh[i], TAG_W'(i + 5), res, tag, sat, lat);
            checks++;
            if (res !== d_exp[i]) begin
                failures++;
                $display("FAIL directed_res[%0d]: got %h want %h", i, res, d_exp[i]);
            end
            checks++;
            if (tag !== TAG_W'(i + 5)) begin
                failures++;
                $display("FAIL directed_tag[%0d]: got %h want %h", i, tag, TAG_W'(i + 5));
            end
            checks++;
            if (lat != 2) begin
                failures++; $display("FAIL directed_latency[%0d]: got %0d want 2", i, lat);
            end
`ifdef MAN_SHIFTR_SAT_EN
            checks++;
            if (sat !== (d_sh[i] >= 8'd26)) begin
                failures++;
                $display("FAIL directed_sat[%0d]: got %b want %b", i, sat, d_sh[i] >= 8'd26);
            end
`endif
        end
        step();
    endtask

    task automatic test_sweep();
        logic [MAN_W-1:0] m;
        logic [MAN_W+2:0] exp;
        for (int sh = 0; sh <= int'(MAN_W) + 4; sh++) begin
            m   = MAN_W'($urandom);
            exp = ref_res(m, sh);
            out_ready = 1'b1;
            drive(1'b1, m, SHAMT_W'(sh), TAG_W'(sh));
            #1;
            checks++;
            if ({in_ready1, in_ready, in_ready4} !== 3'b111) begin
                failures++;
                $display("FAIL sweep_in_ready[%0d]: got %b want 111",
                         sh, {in_ready1, in_ready, in_ready4});
            end
            step();
            in_valid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                if (c == 1) begin
                    checks++;
                    if (out_valid1 !== 1'b1 || out_res1 !== exp || out_tag1 !== TAG_W'(sh)) begin
                        failures++;
                        $display("FAIL sweep_s1[%0d]: got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                                 sh, out_valid1, out_res1, out_tag1, exp, TAG_W'(sh));
                    end
`ifdef MAN_SHIFTR_SAT_EN
                    checks++;
                    if (out_sat1 !== (sh >= int'(EXT_W))) begin
                        failures++;
                        $display("FAIL sweep_s1_sat[%0d]: got %b want %b",
                                 sh, out_sat1, sh >= int'(EXT_W));
                    end
`endif
                end
                if (c == 2) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_res !== exp || out_tag !== TAG_W'(sh)) begin
                        failures++;
                        $display("FAIL sweep_s2[%0d]: got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                                 sh, out_valid, out_res, out_tag, exp, TAG_W'(sh));
                    end
                end
                if (c == 4) begin
                    checks++;
                    if (out_valid4 !== 1'b1 || out_res4 !== exp || out_tag4 !== TAG_W'(sh)) begin
                        failures++;
                        $display("FAIL sweep_s4[%0d]: got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                                 sh, out_valid4, out_res4, out_tag4, exp, TAG_W'(sh));
                    end
`ifdef MAN_SHIFTR_SAT_EN
                    checks++;
                    if (out_sat4 !== (sh >= int'(EXT_W))) begin
                        failures++;
                        $display("FAIL sweep_s4_sat[%0d]: got %b want %b",
                                 sh, out_sat4, sh >= int'(EXT_W));
                    end
`endif
                end
                step();
            end
        end
    endtask

    task automatic test_backpressure();
        logic [MAN_W+2:0]   q_res [$];
        logic [TAG_W-1:0]   q_tag [$];
        logic [MAN_W-1:0]   m;
        logic [SHAMT_W-1:0] s;
        logic [MAN_W+2:0]   held_res;
        logic [TAG_W-1:0]   held_tag;
        logic [MAN_W+2:0]   e_res;
        logic [TAG_W-1:0]   e_tag;
        int                 sent;
        int                 got;
        sent     = 0;
        got      = 0;
        held_res = '0;
        held_tag = '0;
        m = MAN_W'($urandom);
        s = SHAMT_W'($urandom_range(0, 30));
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 5);
            if (sent < 3) drive(1'b1, m, s, TAG_W'(sent + 1));
            else          drive(1'b0, '0, '0, '0);
            #1;
            if (c <= 4) begin
                checks++;
                if (in_ready !== (c < 2)) begin
                    failures++;
                    $display("FAIL bp_in_ready[c%0d]: got %b want %b", c, in_ready, c < 2);
                end
            end
            if (c == 2) begin
                held_res = out_res;
                held_tag = out_tag;
            end
            if (c >= 3 && c <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_res !== held_res || out_tag !== held_tag) begin
                    failures++;
                    $display("FAIL bp_hold[c%0d]: got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                             c, out_valid, out_res, out_tag, held_res, held_tag);
                end
            end
            if (in_valid && in_ready) begin
                q_res.push_back(ref_res(m, int'(s)));
                q_tag.push_back(TAG_W'(sent + 1));
                sent++;
                m = MAN_W'($urandom);
                s = SHAMT_W'($urandom_range(0, 30));
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (q_tag.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra: got tag=%h want no result", out_tag);
                end else begin
                    e_res = q_res.pop_front();
                    e_tag = q_tag.pop_front();
                    if (out_res !== e_res || out_tag !== e_tag) begin
                        failures++;
                        $display("FAIL bp_result: got res=%h tag=%h want res=%h tag=%h",
                                 out_res, out_tag, e_res, e_tag);
                    end
                end
            end
            step();
        end
        checks++;
        if (got != 3 || sent != 3) begin
            failures++; $display("FAIL bp_count: got %0d/%0d want 3/3", got, sent);
        end
    endtask

    task automatic test_back_to_back();
        logic [MAN_W+2:0]   q_res [$];
        logic [TAG_W-1:0]   q_tag [$];
        logic [MAN_W-1:0]   m;
        logic [SHAMT_W-1:0] s;
        logic [TAG_W-1:0]   t;
        logic               pend;
        logic               hold;
        logic [MAN_W+2:0]   held_res;
        logic [TAG_W-1:0]   held_tag;
        logic [MAN_W+2:0]   e_res;
        logic [TAG_W-1:0]   e_tag;
        int                 acc;
        int                 emi;
        pend = 1'b0;
        hold = 1'b0;
        acc  = 0;
        emi  = 0;
        m = '0; s = '0; t = '0;
        held_res = '0; held_tag = '0;
        for (int c = 0; c < 340; c++) begin
            if (!pend && c < 320 && (c >= 300 || $urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                m = MAN_W'($urandom);
                s = ($urandom_range(0, 9) == 0) ? SHAMT_W'($urandom)
                                                : SHAMT_W'($urandom_range(0, 30));
                t = TAG_W'($urandom);
            end
            drive(pend, m, s, t);
            out_ready = (c >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_res !== held_res || out_tag !== held_tag) begin
                    failures++;
                    $display("FAIL b2b_stable[c%0d]: got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                             c, out_valid, out_res, out_tag, held_res, held_tag);
                end
            end
            if (c >= 300 && c < 320) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++; $display("FAIL b2b_full_rate[c%0d]: got %b want 1", c, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                q_res.push_back(ref_res(m, int'(s)));
                q_tag.push_back(t);
                pend = 1'b0;
                acc++;
            end
            if (out_valid && out_ready) begin
                emi++;
                checks++;
                if (q_tag.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: got tag=%h want no result", out_tag);
                end else begin
                    e_res = q_res.pop_front();
                    e_tag = q_tag.pop_front();
                    if (out_res !== e_res || out_tag !== e_tag) begin
                        failures++;
                        $display("FAIL b2b_result[c%0d]: got res=%h tag=%h want res=%h tag=%h",
                                 c, out_res, out_tag, e_res, e_tag);
                    end
                end
            end
            hold     = out_valid && !out_ready;
            held_res = out_res;
            held_tag = out_tag;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (emi != acc || q_tag.size() != 0) begin
            failures++;
            $display("FAIL b2b_count: got emitted=%0d want %0d (pending %0d)",
                     emi, acc, q_tag.size());
        end
    endtask

    task automatic test_reset_flush();
        logic [MAN_W+2:0] res;
        logic [TAG_W-1:0] tag;
        logic             sat;
        logic             seen;
        logic [MAN_W-1:0] m;
        logic [SHAMT_W-1:0] s;
        int               lat;
        out_ready = 1'b0;
        drive(1'b1, MAN_W'($urandom), 8'd2, 4'hA);
        #1;
        step();
        drive(1'b1, MAN_W'($urandom), 8'd5, 4'hB);
        step();
        drive(1'b0, '0, '0, '0);
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_after_rst: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL flush_ghost: got out_valid=1 want 0");
        end
        m = MAN_W'($urandom);
        s = SHAMT_W'($urandom_range(0, 27));
        run_one(m, s, 4'h3, res, tag, sat, lat);
        checks++;
        if (lat != 2 || res !== ref_res(m, int'(s)) || tag !== 4'h3) begin
            failures++;
            $display("FAIL flush_fresh: got lat=%0d res=%h tag=%h want lat=2 res=%h tag=3",
                     lat, res, tag, ref_res(m, int'(s)));
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
